// File: rtl/opb_register_bank_ppc2simulink.sv
// ---------------------------------------------------------------------------
// opb_register_bank_ppc2simulink
//
// Bank of C_NUM_REGS PPC-writable 32-bit registers behind one OPB slave
// window. It supports byte-enable writes, readback, and a one-cycle update
// strobe per register. Registers selected by C_PULSE_MASK are self-clearing
// triggers: a written value is visible for exactly one cycle.
//
// Optional feature (macro PPC2SIM_WRITE_COUNT_EN):
//   Index C_NUM_REGS becomes a read-only counter of accepted in-range writes.
//
// Ports:
//   OPB_Clk, OPB_Rst      clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW  OPB transfer request (big-endian bit numbering)
//   OPB_select            transfer request strobe
//   OPB_seqAddr           unused hint
//   Sl_DBus, Sl_xferAck   registered read data / one-cycle acknowledge
//   Sl_errAck/retry/toutSup tied low
//   user_data_out         register i at bits [32i+31:32i]
//   user_update           one-cycle strobe per register written
// ---------------------------------------------------------------------------
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01010500,
  parameter logic [31:0] C_HIGHADDR   = 32'h010105FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter int unsigned C_NUM_REGS   = 4,
  parameter logic [63:0] C_PULSE_MASK = 64'h0,
  parameter logic [31:0] C_RESET_VAL  = 32'h0
) (
  input  logic                          OPB_Clk,
  input  logic                          OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]       OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]     OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]       OPB_DBus,
  input  logic                          OPB_RNW,
  input  logic                          OPB_select,
  input  logic                          OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]       Sl_DBus,
  output logic                          Sl_errAck,
  output logic                          Sl_retry,
  output logic                          Sl_toutSup,
  output logic                          Sl_xferAck,
  output logic [32*C_NUM_REGS-1:0]      user_data_out,
  output logic [C_NUM_REGS-1:0]         user_update
);

  localparam int unsigned AW = C_OPB_AWIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_HOLD
  } state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            addr_c, offset_c, idx_c;
  logic                     hit_c;
  logic [31:0]              rdata_c;

  logic [AW-1:0]            idx_q, idx_d;
  logic                     rnw_q, rnw_d;
  logic [0:3]               be_q, be_d;
  logic [31:0]              wdata_q, wdata_d;
  logic                     ack_q, ack_d;
  logic [31:0]              dbus_q, dbus_d;
  logic [C_NUM_REGS-1:0]    upd_q, upd_d;
  logic [31:0]              regs_q [C_NUM_REGS];
  logic [31:0]              regs_d [C_NUM_REGS];

`ifdef PPC2SIM_WRITE_COUNT_EN
  logic [31:0]              wcount_q, wcount_d;
`endif

  logic                     unused_seqaddr;
  assign unused_seqaddr = OPB_seqAddr;

  // Address decode
  assign addr_c   = OPB_ABus;
  assign hit_c    = OPB_select && (addr_c >= AW'(C_BASEADDR)) && (addr_c <= AW'(C_HIGHADDR));
  assign offset_c = addr_c - AW'(C_BASEADDR);
  assign idx_c    = offset_c >> 2;

  // Read mux; out-of-range indices read as zero
  always_comb begin
    rdata_c = '0;
    for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
      if (idx_c == AW'(i)) rdata_c = regs_q[i];
    end
`ifdef PPC2SIM_WRITE_COUNT_EN
    if (idx_c == AW'(C_NUM_REGS)) rdata_c = wcount_q;
`endif
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rnw_d    = rnw_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    ack_d    = 1'b0;
    dbus_d   = '0;
    upd_d    = '0;
`ifdef PPC2SIM_WRITE_COUNT_EN
    wcount_d = wcount_q;
`endif
    // Trigger registers fall back to the idle value unless written this edge
    for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
      regs_d[i] = C_PULSE_MASK[i] ? C_RESET_VAL : regs_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (hit_c) begin
          state_d = ST_ACK;
          idx_d   = idx_c;
          rnw_d   = OPB_RNW;
          be_d    = OPB_BE;
          wdata_d = OPB_DBus;
          ack_d   = 1'b1;
          // Read data is registered alongside the ack so it is valid during
          // ACK; register contents cannot change between sample and ACK.
          if (OPB_RNW) dbus_d = rdata_c;
        end
      end
      ST_ACK: begin
        state_d = ST_HOLD;
        if (!rnw_q) begin
          for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            if (idx_q == AW'(i)) begin
              regs_d[i] = regs_q[i];
              for (int unsigned b = 0; b < 4; b++) begin
                if (be_q[b]) regs_d[i][31-8*b -: 8] = wdata_q[31-8*b -: 8];
              end
              upd_d[i] = 1'b1;
            end
          end
`ifdef PPC2SIM_WRITE_COUNT_EN
          if (idx_q < AW'(C_NUM_REGS)) wcount_d = wcount_q + 32'd1;
`endif
        end
      end
      // Select is ignored here so a master still holding select after the
      // ack does not get acknowledged twice.
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      rnw_q    <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      dbus_q   <= '0;
      upd_q    <= '0;
      for (int unsigned i = 0; i < C_NUM_REGS; i++) regs_q[i] <= C_RESET_VAL;
`ifdef PPC2SIM_WRITE_COUNT_EN
      wcount_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rnw_q    <= rnw_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      dbus_q   <= dbus_d;
      upd_q    <= upd_d;
      for (int unsigned i = 0; i < C_NUM_REGS; i++) regs_q[i] <= regs_d[i];
`ifdef PPC2SIM_WRITE_COUNT_EN
      wcount_q <= wcount_d;
`endif
    end
  end

  always_comb begin
    user_data_out = '0;
    for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
      user_data_out[32*i +: 32] = regs_q[i];
    end
  end

  assign Sl_DBus     = dbus_q;
  assign Sl_xferAck  = ack_q;
  assign user_update = upd_q;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE  = 32'h01010500;
  localparam logic [31:0] HIGH  = 32'h010105FF;
  localparam int          NREG  = 4;
  localparam logic [63:0] PULSE = 64'h1;
  localparam logic [31:0] RV    = 32'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [0:31]   tb_abus = '0;
  logic [0:3]    tb_be = '0;
  logic [0:31]   tb_dbus = '0;
  logic          tb_rnw = 1'b0;
  logic          tb_sel = 1'b0;
  logic          tb_seq = 1'b0;
  logic [0:31]   sl_dbus;
  logic          sl_errack, sl_retry, sl_toutsup, sl_xferack;
  logic [127:0]  udo;
  logic [3:0]    upd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR  (BASE),
    .C_HIGHADDR  (HIGH),
    .C_NUM_REGS  (NREG),
    .C_PULSE_MASK(PULSE),
    .C_RESET_VAL (RV)
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst      (rst),
    .OPB_ABus     (tb_abus),
    .OPB_BE       (tb_be),
    .OPB_DBus     (tb_dbus),
    .OPB_RNW      (tb_rnw),
    .OPB_select   (tb_sel),
    .OPB_seqAddr  (tb_seq),
    .Sl_DBus      (sl_dbus),
    .Sl_errAck    (sl_errack),
    .Sl_retry     (sl_retry),
    .Sl_toutSup   (sl_toutsup),
    .Sl_xferAck   (sl_xferack),
    .user_data_out(udo),
    .user_update  (upd)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         idx;
    logic [0:3] be;
    logic [31:0] data;
  } wr_t;

  logic [31:0] m [NREG];
  int unsigned wcnt = 0;
  bit          started = 0;
  bit          rst_pend = 0;
  int          last_acc = -100;
  bit          ack_at [int];
  int          rd_at  [int];
  wr_t         wr_at  [int];
  int          rv_at  [int];

  function automatic logic [31:0] mread(input int ix);
    if (ix < NREG) return m[ix];
`ifdef PPC2SIM_WRITE_COUNT_EN
    if (ix == NREG) return wcnt;
`endif
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    int           c;
    int           ix;
    logic [31:0]  a;
    logic [127:0] e_udo;
    logic [3:0]   e_upd;
    logic [31:0]  e_db;
    bit           e_ack;
    wr_t          w;
    c     = cyc;
    e_upd = '0;
    if (rst_pend) begin
      rst_pend = 0;
      started  = 1;
      for (int i = 0; i < NREG; i++) m[i] = RV;
      wcnt = 0;
      last_acc = -100;
      ack_at.delete(); rd_at.delete(); wr_at.delete(); rv_at.delete();
    end else begin
      if (wr_at.exists(c)) begin
        w = wr_at[c];
        wr_at.delete(c);
        if (w.idx < NREG) begin
          for (int b = 0; b < 4; b++)
            if (w.be[b]) m[w.idx][31-8*b -: 8] = w.data[31-8*b -: 8];
          e_upd[w.idx] = 1'b1;
          if (PULSE[w.idx]) rv_at[c+1] = w.idx;
          wcnt++;
        end
      end
      if (rv_at.exists(c)) begin
        m[rv_at[c]] = RV;
        rv_at.delete(c);
      end
    end
    e_ack = ack_at.exists(c);
    e_db  = '0;
    if (e_ack) begin
      ack_at.delete(c);
      if (rd_at.exists(c)) begin
        e_db = mread(rd_at[c]);
        rd_at.delete(c);
      end
    end
    e_udo = '0;
    for (int i = 0; i < NREG; i++) e_udo[32*i +: 32] = m[i];
    if (started) begin
      check("xferAck", 128'(sl_xferack), 128'(e_ack));
      check("Sl_DBus", 128'(sl_dbus), 128'(e_db));
      check("user_data_out", udo, e_udo);
      check("user_update", 128'(upd), 128'(e_upd));
      check("tied_zero", 128'({sl_errack, sl_retry, sl_toutsup}), 128'(0));
    end
    // observe this cycle's inputs (sampled by the DUT at the next edge)
    a = tb_abus;
    if (rst) rst_pend = 1;
    else if (started && tb_sel && a >= BASE && a <= HIGH && c >= last_acc + 3) begin
      last_acc  = c;
      ix        = int'((a - BASE) >> 2);
      ack_at[c+1] = 1;
      if (tb_rnw) rd_at[c+1] = ix;
      else begin
        w.idx = ix; w.be = tb_be; w.data = tb_dbus;
        wr_at[c+2] = w;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after n select cycles.
  task automatic drive(input logic [31:0] a, input logic r, input logic [0:3] b,
                       input logic [31:0] d, input int n, input logic rf);
    rst = rf; tb_abus = a; tb_rnw = r; tb_be = b; tb_dbus = d; tb_sel = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      rst = 1'b0;
    end
    tb_sel = 1'b0;
  endtask

  task automatic rd_lit(input int ix, input logic [31:0] exp, input string name);
    drive(BASE + 32'(4*ix), 1'b1, 4'hF, $urandom(), 1, 1'b0);
    @(negedge clk);
    check({name, "_ack"}, 128'(sl_xferack), 128'(1));
    check(name, 128'(sl_dbus), 128'(exp));
    tick(2);
  endtask

  task automatic wr_wait(input logic [31:0] a, input logic [0:3] b, input logic [31:0] d);
    drive(a, 1'b0, b, d, 1, 1'b0);
    tick(2);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] exp_cnt;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_udo", udo, 128'h0);
    check("rst_upd", 128'(upd), 128'h0);
    check("rst_ack", 128'(sl_xferack), 128'h0);
    check("rst_dbus", 128'(sl_dbus), 128'h0);
    tick(1);

    for (int i = 0; i < NREG; i++) rd_lit(i, 32'h0, "rst_read");

    // full-word write to idx 1
    drive(32'h01010504, 1'b0, 4'b1111, 32'hDEADBEEF, 1, 1'b0);
    @(negedge clk);
    check("wr_ack_n1", 128'(sl_xferack), 128'h1);
    @(negedge clk);
    check("wr_udo_n2", 128'(udo[63:32]), 128'hDEADBEEF);
    check("wr_upd_n2", 128'(upd), 128'(4'b0010));
    tick(1);
    rd_lit(1, 32'hDEADBEEF, "rd_deadbeef");

    // byte-enable merge
    wr_wait(BASE + 32'd4, 4'b0101, 32'h11223344);
    rd_lit(1, 32'hDE22BE44, "rd_be_merge");

    // pulse register idx 0
    drive(BASE, 1'b0, 4'b1111, 32'h1, 1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pulse_n2", 128'(udo[31:0]), 128'h1);
    check("pulse_upd", 128'(upd), 128'(4'b0001));
    @(negedge clk);
    check("pulse_n3", 128'(udo[31:0]), 128'h0);
    tick(1);
    rd_lit(0, 32'h0, "pulse_read");

    // select held for 6 cycles
    tb_abus = BASE + 32'd4; tb_rnw = 1'b1; tb_be = 4'hF; tb_sel = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("hold_ack", 128'(sl_xferack), 128'((j == 1 || j == 4) ? 1 : 0));
    end
    tick(1);
    tb_sel = 1'b0;
    tick(1);

    // out-of-range write
    drive(32'h01010540, 1'b0, 4'b1111, 32'hCAFEF00D, 1, 1'b0);
    @(negedge clk);
    check("oor_ack", 128'(sl_xferack), 128'h1);
    @(negedge clk);
    check("oor_udo", udo, {64'h0, 32'hDE22BE44, 32'h0});
    check("oor_upd", 128'(upd), 128'h0);
    tick(1);

    // reset during the ACK cycle of a write
    drive(BASE + 32'd8, 1'b0, 4'b1111, 32'h55AA55AA, 1, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("rstack_udo", udo, 128'h0);
    check("rstack_upd", 128'(upd), 128'h0);
    check("rstack_ack", 128'(sl_xferack), 128'h0);
    @(negedge clk);
    check("rstack_lost", 128'(udo[95:64]), 128'h0);
    tick(1);

    // write counter index
    wr_wait(BASE + 32'd8,  4'hF, 32'h1);
    wr_wait(BASE + 32'd12, 4'hF, 32'h2);
    wr_wait(BASE + 32'd4,  4'hF, 32'h3);
`ifdef PPC2SIM_WRITE_COUNT_EN
    exp_cnt = 32'h3;
`else
    exp_cnt = 32'h0;
`endif
    rd_lit(NREG, exp_cnt, "wcount");

    // randomized traffic against the model
    for (int t = 0; t < 400; t++) begin
      int sel_kind;
      tick($urandom_range(0, 2));
      sel_kind = $urandom_range(0, 9);
      if (sel_kind < 7)      a = BASE + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
      else if (sel_kind < 8) a = BASE + 32'($urandom_range(0, 255));
      else if (sel_kind < 9) a = BASE - 32'($urandom_range(1, 64));
      else                   a = HIGH + 32'($urandom_range(1, 64));
      drive(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
            $urandom_range(1, 4), ($urandom_range(0, 39) == 0));
    end
    tick(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
- Parametrised successor to the single software-to-fabric OPB register.
- Provides C_NUM_REGS PPC-writable 32-bit registers behind one OPB slave window, with byte-enable writes, readback, per-register update strobes and optional self-clearing trigger registers.
- Sits between the OPB bus and Simulink user logic, for example snap triggers and control words.
- Runs entirely in the OPB clock domain; user logic on that same clock.

Parameters:
- C_BASEADDR, 32'h01010500: first byte address of the window.
- C_HIGHADDR, 32'h010105FF: last byte address of the window.
- C_OPB_AWIDTH, 32: OPB address width.
- C_OPB_DWIDTH, 32: OPB data width. Only 32 is supported.
- C_NUM_REGS, 4: number of registers, 1..64.
- C_PULSE_MASK, 64'h0: bit i set makes register i a self-clearing trigger register.
- C_RESET_VAL, 32'h0: reset/idle value of every register.

Ports:
- OPB_Clk  in  1  clock for everything.
- OPB_Rst  in  1  synchronous, active-high reset.
- OPB_ABus  in  [0:31]  byte address.
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7].
- OPB_DBus  in  [0:31]  write data; bit 0 is the MSB.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  sequential hint; ignored.
- Sl_DBus  out  [0:31]  read data; all zeros except during a read ack.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- user_data_out  out  [32*C_NUM_REGS-1:0]  register i occupies bits [32i+31:32i]; OPB_DBus[0] maps to bit 31.
- user_update  out  [C_NUM_REGS-1:0]  one-cycle strobe, register i changed by OPB write.

Behaviour:
- Reset (sampled on OPB_Clk):
  - All registers = C_RESET_VAL.
  - Sl_xferAck = 0, Sl_DBus = 0, user_update = 0.
  - FSM = IDLE.
  - A reset that coincides with ACK drops the pending write; ack is 0 from the next cycle.
- Decode:
  - hit = OPB_select and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
  - idx = (OPB_ABus - C_BASEADDR) >> 2; ABus[30:31] ignored.
  - idx >= C_NUM_REGS: the transfer is still acked; writes are discarded and reads return 0.
- FSM:
  - IDLE: on hit, capture idx, RNW, BE and DBus; go to ACK.
  - ACK: Sl_xferAck = 1 for exactly one cycle.
    - Read: Sl_DBus = register[idx] during ACK only.
    - Write: the register is updated at the rising edge that ends ACK.
    - Go to HOLD.
  - HOLD: ack = 0; OPB_select is ignored; go to IDLE. This prevents a double ack while the master drops select.
- Latency: select sampled at cycle N, ack at cycle N+1, write visible on user_data_out at N+2. Back-to-back transfers are acked at most every 3 cycles.
- Byte enables: for each b in 0..3, if BE[b], register bits [31-8b -: 8] = DBus[8b +: 8]. With BE = 0, data is unchanged but user_update still pulses.
- user_update[i]:
  - High for exactly one cycle (N+2), aligned with the new value, on any accepted write to i.
  - A write to an out-of-range idx pulses nothing.
- Pulse registers (C_PULSE_MASK[i] = 1):
  - The written value is present for exactly one cycle (N+2).
  - The register then returns to C_RESET_VAL at N+3.
  - Readback returns the current value, normally C_RESET_VAL.
- Non-pulse registers hold their value until the next write or reset.
- Sl_DBus, Sl_xferAck and user_data_out are all registered outputs; no combinational path from OPB inputs.

Optional Feature:
- Macro: PPC2SIM_WRITE_COUNT_EN.
- Defined:
  - idx == C_NUM_REGS is a read-only 32-bit counter of accepted in-range writes.
  - The counter increments at the same edge the register updates and wraps 32'hFFFFFFFF -> 0.
  - Reset clears it. Writes to this index are acked and ignored.
- Undefined: that index reads 0 like any other out-of-range index; no counter logic is generated.

Test Plan:
- Reset, then read idx 0..3 -> Sl_DBus = 0 on each ack; Sl_DBus = 0 outside ack; user_update = 0.
- Write 32'hDEADBEEF to 0x01010504 with BE = 4'b1111 -> ack at N+1; user_data_out[63:32] = 32'hDEADBEEF and user_update = 4'b0010 at N+2; readback returns 32'hDEADBEEF.
- Write 32'h11223344 to idx 1 with BE = 4'b0101 -> register = 32'hDE22BE44.
- C_PULSE_MASK = 1: write 32'h1 to idx 0 -> user_data_out[31:0] = 1 for exactly one cycle, then 0; a subsequent read returns 0.
- Hold OPB_select high for 6 cycles -> Sl_xferAck pulses at N+1 and N+4 only; write to 0x01010540 -> acked, no register change, no user_update.
- Assert OPB_Rst during an ACK cycle of a write -> write lost, all outputs reset next cycle. With PPC2SIM_WRITE_COUNT_EN, 3 writes then read idx C_NUM_REGS -> returns 32'h3.
